// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// ALU/extender/next-PC select codes and the FSM state enumeration.
package mips_mc_pkg;

  // Primary opcodes (Instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes (Instruction[5:0])
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // ALU operation select
  localparam logic [3:0] ALU_ADDU = 4'b0000;
  localparam logic [3:0] ALU_SUBU = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_PASSB = 4'b0100;

  // Immediate extender mode
  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  // Next-PC source
  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_JMP = 2'b10;
  localparam logic [1:0] NPC_REG = 2'b11;

  // Controller states; FETCH must stay at zero (it is the reset state)
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE_R  = 4'd2,
    S_EXE_I  = 4'd3,
    S_MEMADR = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWR  = 4'd6,
    S_WB     = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational instruction classifier: turns the latched IR into a one-hot
// instruction class plus the ALU operation and extender mode it needs.
module mips_mc_decode
  import mips_mc_pkg::*;
(
  input  logic [31:0] instruction,
  output logic        rtype_alu,
  output logic        itype_alu,
  output logic        load,
  output logic        store,
  output logic        branch,
  output logic        jump,
  output logic        illegal,
  output logic [3:0]  alu_ctr,
  output logic [1:0]  ext_op,
  output logic        is_lb,
  output logic        is_addi,
  output logic        is_jal,
  output logic        is_jr
);

  logic [5:0] op;
  logic [5:0] fn;
  // Register and immediate fields are routed to the datapath, not used here.
  logic       unused_fields;

  assign op            = instruction[31:26];
  assign fn            = instruction[5:0];
  assign unused_fields = ^instruction[25:6];

  // Classify opcode/funct; anything not recognised is flagged illegal.
  always_comb begin
    rtype_alu = 1'b0;
    itype_alu = 1'b0;
    load      = 1'b0;
    store     = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    illegal   = 1'b0;
    alu_ctr   = ALU_ADDU;
    ext_op    = EXT_ZERO;
    is_lb     = 1'b0;
    is_addi   = 1'b0;
    is_jal    = 1'b0;
    is_jr     = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU: rtype_alu = 1'b1;
          FN_SUBU: begin
            rtype_alu = 1'b1;
            alu_ctr   = ALU_SUBU;
          end
          FN_JR: begin
            jump  = 1'b1;
            is_jr = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_ORI: begin
        itype_alu = 1'b1;
        alu_ctr   = ALU_OR;
        ext_op    = EXT_ZERO;
      end
      OP_LUI: begin
        itype_alu = 1'b1;
        alu_ctr   = ALU_PASSB;
        ext_op    = EXT_UPPER;
      end
      OP_ADDI: begin
        itype_alu = 1'b1;
        is_addi   = 1'b1;
        alu_ctr   = ALU_ADD;
        ext_op    = EXT_SIGN;
      end
      OP_LW: begin
        load   = 1'b1;
        ext_op = EXT_SIGN;
      end
      OP_LB: begin
        load   = 1'b1;
        is_lb  = 1'b1;
        ext_op = EXT_SIGN;
      end
      OP_SW: begin
        store  = 1'b1;
        ext_op = EXT_SIGN;
      end
      OP_BEQ: begin
        branch  = 1'b1;
        alu_ctr = ALU_SUBU;
        ext_op  = EXT_SIGN;
      end
      OP_J:   jump = 1'b1;
      OP_JAL: begin
        jump   = 1'b1;
        is_jal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: steps each instruction through
// FETCH/DECODE/execute/memory/write-back and drives all datapath controls.
// Every output is forced low while rst is high so no write can slip out
// during the reset cycle.
module mips_mc_ctrl
  import mips_mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instruction,
  input  logic        zero,
  input  logic        over,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RegDst,
  output logic        RegWr,
  output logic        MemtoReg,
  output logic        MemWr,
  output logic        ALUSrc,
  output logic        j_sel,
  output logic        jal_sel,
  output logic        lb_sel,
  output logic [1:0]  ExtOp,
  output logic [1:0]  nPC_sel,
  output logic [3:0]  ALUctr,
  output logic        instr_done,
  output logic        illegal,
  output logic [3:0]  state
);

  state_t     state_q;
  state_t     state_d;

  logic       dec_rtype;
  logic       dec_itype;
  logic       dec_load;
  logic       dec_store;
  logic       dec_branch;
  logic       dec_jump;
  logic       dec_illegal;
  logic [3:0] dec_alu;
  logic [1:0] dec_ext;
  logic       dec_lb;
  logic       dec_addi;
  logic       dec_jal;
  logic       dec_jr;

  mips_mc_decode u_decode (
    .instruction (Instruction),
    .rtype_alu   (dec_rtype),
    .itype_alu   (dec_itype),
    .load        (dec_load),
    .store       (dec_store),
    .branch      (dec_branch),
    .jump        (dec_jump),
    .illegal     (dec_illegal),
    .alu_ctr     (dec_alu),
    .ext_op      (dec_ext),
    .is_lb       (dec_lb),
    .is_addi     (dec_addi),
    .is_jal      (dec_jal),
    .is_jr       (dec_jr)
  );

  // State register; reset always returns to FETCH.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state selection from the current state and instruction class.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if      (dec_rtype)            state_d = S_EXE_R;
        else if (dec_itype)            state_d = S_EXE_I;
        else if (dec_load | dec_store) state_d = S_MEMADR;
        else if (dec_branch)           state_d = S_BRANCH;
        else if (dec_jump)             state_d = S_JUMP;
        else                           state_d = S_FETCH;
      end
      S_EXE_R:  state_d = S_WB;
      S_EXE_I:  state_d = S_WB;
      S_MEMADR: state_d = dec_store ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_WB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Per-state control decode; all controls idle low while in reset.
  always_comb begin
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    RegDst     = 1'b0;
    RegWr      = 1'b0;
    MemtoReg   = 1'b0;
    MemWr      = 1'b0;
    ALUSrc     = 1'b0;
    j_sel      = 1'b0;
    jal_sel    = 1'b0;
    lb_sel     = 1'b0;
    ExtOp      = EXT_ZERO;
    nPC_sel    = NPC_SEQ;
    ALUctr     = ALU_ADDU;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          PCWr = 1'b1;
          IRWr = 1'b1;
        end
        S_DECODE: illegal = dec_illegal;
        S_EXE_R:  ALUctr = dec_alu;
        S_EXE_I: begin
          ALUSrc = 1'b1;
          ExtOp  = dec_ext;
          ALUctr = dec_alu;
        end
        S_MEMADR: begin
          ALUSrc = 1'b1;
          ExtOp  = EXT_SIGN;
        end
        S_MEMRD: begin
          ALUSrc = 1'b1;
          ExtOp  = EXT_SIGN;
          lb_sel = dec_lb;
        end
        S_MEMWR: begin
          ALUSrc     = 1'b1;
          ExtOp      = EXT_SIGN;
          MemWr      = 1'b1;
          instr_done = 1'b1;
        end
        S_WB: begin
          instr_done = 1'b1;
          RegWr      = 1'b1;
          // ALU inputs stay as in the execute/address phase so the result
          // feeding the register file does not glitch during write-back.
          if (dec_rtype) begin
            RegDst = 1'b1;
            ALUctr = dec_alu;
          end else if (dec_itype) begin
            ALUSrc = 1'b1;
            ExtOp  = dec_ext;
            ALUctr = dec_alu;
            // Signed overflow on addi cancels the register write.
            RegWr  = ~(dec_addi & over);
          end else begin
            ALUSrc   = 1'b1;
            ExtOp    = EXT_SIGN;
            MemtoReg = 1'b1;
          end
        end
        S_BRANCH: begin
          ALUctr     = ALU_SUBU;
          ExtOp      = EXT_SIGN;
          nPC_sel    = NPC_BR;
          PCWr       = zero;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          PCWr       = 1'b1;
          j_sel      = 1'b1;
          nPC_sel    = dec_jr ? NPC_REG : NPC_JMP;
          jal_sel    = dec_jal;
          RegWr      = dec_jal;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = rst ? 4'd0 : state_q;

endmodule
